// File: rtl/k12a_sequencer.sv
// k12a state sequencer: owns the decoder's state register and stretches memory
// states to WAIT_STATES+1 cycles, with write shaping, wake sync, single-step and retire count.
package k12a_pkg;
    typedef enum logic [2:0] {
        STATE_FETCH1 = 3'd0,
        STATE_FETCH2 = 3'd1,
        STATE_EXEC   = 3'd2,
        STATE_POP    = 3'd3,
        STATE_RJMP   = 3'd4,
        STATE_HALT   = 3'd5
    } state_t;
endpackage

module k12a_sequencer
    import k12a_pkg::*;
#(
    parameter int WAIT_STATES    = 2,
    parameter int WRITE_SETUP    = 1,
    parameter int USE_READY      = 0,
    parameter int WAKE_SYNC      = 2,
    parameter int CNT_WIDTH      = 4,
    parameter int INST_CNT_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  state_t                    state_next_req,
    input  logic                      mem_access,
    input  logic                      mem_write,
    input  logic                      mem_ready,
    input  logic                      wake,
    input  logic                      step_mode,
    input  logic                      step_req,
    output state_t                    state,
    output logic                      commit,
    output logic                      stall,
    output logic                      async_write,
    output logic                      wake_synced,
    output logic                      halted,
    output logic [INST_CNT_WIDTH-1:0] inst_count
);

    localparam logic [CNT_WIDTH-1:0] LP_WAIT  = CNT_WIDTH'(WAIT_STATES);
    localparam logic [CNT_WIDTH-1:0] LP_SETUP = CNT_WIDTH'(WRITE_SETUP);

    if (WAIT_STATES < WRITE_SETUP + 1) begin : g_chkSetup
        $error("k12a_sequencer: WAIT_STATES must be at least WRITE_SETUP+1");
    end
    if (WAIT_STATES >= (2 ** CNT_WIDTH)) begin : g_chkCnt
        $error("k12a_sequencer: WAIT_STATES does not fit in CNT_WIDTH bits");
    end

    state_t                    r_state;
    state_t                    w_stateNext;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic [CNT_WIDTH-1:0]      w_cntNext;
    logic                      r_token;
    logic                      r_stepPrev;
    logic [INST_CNT_WIDTH-1:0] r_instCount;
    logic                      w_final;
    logic                      w_stepBlock;
    logic                      w_commit;
    logic                      w_stepEdge;
    logic                      w_retire;

    assign w_stepEdge = step_req & ~r_stepPrev;

    // A parked FETCH1 (no step token) never starts its access, so the counter stays at 0.
    always_comb begin
        w_stepBlock = step_mode && (r_state == STATE_FETCH1) && (r_cnt == '0) && !r_token;
        w_final     = 1'b1;
        if (mem_access) begin
            w_final = (r_cnt == LP_WAIT) && ((USE_READY == 0) || mem_ready);
        end
        w_commit    = w_final && !w_stepBlock;
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        if (w_commit) begin
            w_stateNext = state_next_req;
            w_cntNext   = '0;
        end else if (mem_access && (r_cnt < LP_WAIT) && !w_stepBlock) begin
            w_cntNext = r_cnt + 1'b1;
        end
        w_retire = w_commit
                && (r_state inside {STATE_EXEC, STATE_POP, STATE_RJMP})
                && (state_next_req inside {STATE_FETCH1, STATE_HALT});
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= STATE_FETCH1;
            r_cnt       <= '0;
            r_stepPrev  <= 1'b0;
            r_token     <= 1'b0;
            r_instCount <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_stepPrev <= step_req;
            // A new edge outranks the FETCH1 clear so it becomes the next instruction's token.
            if (!step_mode) begin
                r_token <= 1'b0;
            end else if (w_stepEdge) begin
                r_token <= 1'b1;
            end else if (w_commit && (r_state == STATE_FETCH1)) begin
                r_token <= 1'b0;
            end
            if (w_retire) begin
                r_instCount <= r_instCount + 1'b1;
            end
        end
    end

    if (WAKE_SYNC == 0) begin : g_wakeBypass
        assign wake_synced = wake;
    end else begin : g_wakeSync
        logic [WAKE_SYNC-1:0] r_wakeSync;
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_wakeSync <= '0;
            end else begin
                r_wakeSync <= (r_wakeSync << 1) | WAKE_SYNC'(wake);
            end
        end
        assign wake_synced = r_wakeSync[WAKE_SYNC-1];
    end

    // Strobe comes only from the registered count, keeping mem_ready off this path.
    assign async_write = mem_access && mem_write && (r_cnt >= LP_SETUP) && (r_cnt < LP_WAIT);
    assign state       = r_state;
    assign commit      = w_commit;
    assign stall       = ~w_commit;
    assign halted      = (r_state == STATE_HALT);
    assign inst_count  = r_instCount;

endmodule

// File: tb/tb_k12a_sequencer.sv
// Bench for k12a_sequencer: a small decoder model closes the loop around two DUTs
// (defaults, and USE_READY=1 with a 4-bit retire counter); per-cycle expectations are queued.
module tb_k12a_sequencer;
    import k12a_pkg::*;

    localparam logic [1:0] K_MOV = 2'd0;
    localparam logic [1:0] K_ST  = 2'd1;
    localparam logic [1:0] K_HLT = 2'd2;

    typedef struct packed {
        logic        acc;
        logic        wr;
        state_t      nxt;
    } dec_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        commit;
        logic        stall;
        logic        aw;
        logic        halted;
        logic        wsync;
        logic [15:0] icnt;
    } obs_t;

    typedef struct packed {
        logic        rstn;
        logic [1:0]  k;
        logic        rdy;
        logic        wk;
        logic        sm;
        logic        sr;
        obs_t        exp;
    } entry_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       wake;
    logic       stepMode;
    logic       stepReq;
    logic       rdyB;
    logic [1:0] kind;

    state_t     stateA, stateB;
    logic       commitA, stallA, awA, wsyncA, haltedA;
    logic       commitB, stallB, awB, wsyncB, haltedB;
    logic [15:0] icntA;
    logic [3:0]  icntB;
    dec_t       decA, decB;
    obs_t       obsA, obsB;

    entry_t     expQ[$];
    int         checkCount = 0;
    int         passCount  = 0;

    always #5 clock = ~clock;

    function automatic dec_t decode(input state_t st, input logic [1:0] k, input logic ws);
        dec_t d;
        d.acc = 1'b0;
        d.wr  = 1'b0;
        d.nxt = STATE_FETCH1;
        case (st)
            STATE_FETCH1: begin d.acc = 1'b1; d.nxt = STATE_FETCH2; end
            STATE_FETCH2: begin d.acc = 1'b1; d.nxt = STATE_EXEC; end
            STATE_EXEC: begin
                if (k == K_ST) begin d.acc = 1'b1; d.wr = 1'b1; end
                if (k == K_HLT) d.nxt = STATE_HALT;
            end
            STATE_HALT: d.nxt = ws ? STATE_FETCH1 : STATE_HALT;
            default: d.nxt = STATE_FETCH1;
        endcase
        return d;
    endfunction

    always_comb begin
        decA = decode(stateA, kind, wsyncA);
        decB = decode(stateB, kind, wsyncB);
        obsA.st = stateA; obsA.commit = commitA; obsA.stall = stallA; obsA.aw = awA;
        obsA.halted = haltedA; obsA.wsync = wsyncA; obsA.icnt = icntA;
        obsB.st = stateB; obsB.commit = commitB; obsB.stall = stallB; obsB.aw = awB;
        obsB.halted = haltedB; obsB.wsync = wsyncB; obsB.icnt = {12'd0, icntB};
    end

    k12a_sequencer dutA (
        .clock(clock), .reset_n(reset_n), .state_next_req(decA.nxt),
        .mem_access(decA.acc), .mem_write(decA.wr), .mem_ready(1'b0), .wake(wake),
        .step_mode(stepMode), .step_req(stepReq), .state(stateA), .commit(commitA),
        .stall(stallA), .async_write(awA), .wake_synced(wsyncA), .halted(haltedA),
        .inst_count(icntA)
    );

    k12a_sequencer #(.USE_READY(1), .INST_CNT_WIDTH(4)) dutB (
        .clock(clock), .reset_n(reset_n), .state_next_req(decB.nxt),
        .mem_access(decB.acc), .mem_write(decB.wr), .mem_ready(rdyB), .wake(wake),
        .step_mode(stepMode), .step_req(stepReq), .state(stateB), .commit(commitB),
        .stall(stallB), .async_write(awB), .wake_synced(wsyncB), .halted(haltedB),
        .inst_count(icntB)
    );

    function automatic string fmtObs(input obs_t o);
        return $sformatf("st=%0d commit=%b stall=%b aw=%b halted=%b wsync=%b icnt=%0d",
                         o.st, o.commit, o.stall, o.aw, o.halted, o.wsync, o.icnt);
    endfunction

    task automatic pushCycle(input logic rstn, input logic [1:0] k, input logic rdy,
                             input logic wk, input logic sm, input logic sr, input state_t st,
                             input logic c, input logic aw, input logic h, input logic ws,
                             input logic [15:0] ic);
        entry_t e;
        e.rstn = rstn; e.k = k; e.rdy = rdy; e.wk = wk; e.sm = sm; e.sr = sr;
        e.exp.st = st; e.exp.commit = c; e.exp.stall = ~c; e.exp.aw = aw;
        e.exp.halted = h; e.exp.wsync = ws; e.exp.icnt = ic;
        expQ.push_back(e);
    endtask

    // One unstalled instruction: 3-cycle fetches, EXEC 3 cycles for a store, 1 otherwise.
    task automatic pushInstr(input logic [1:0] k, input logic sm, input logic [15:0] ic);
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, k, 1'b1, 1'b0, sm, 1'b0, STATE_FETCH1, i == 2, 1'b0, 1'b0, 1'b0, ic);
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, k, 1'b1, 1'b0, sm, 1'b0, STATE_FETCH2, i == 2, 1'b0, 1'b0, 1'b0, ic);
        if (k == K_ST) begin
            for (int i = 0; i < 3; i++)
                pushCycle(1'b1, k, 1'b1, 1'b0, sm, 1'b0, STATE_EXEC, i == 2, i == 1, 1'b0, 1'b0, ic);
        end else begin
            pushCycle(1'b1, k, 1'b1, 1'b0, sm, 1'b0, STATE_EXEC, 1'b1, 1'b0, 1'b0, 1'b0, ic);
        end
    endtask

    task automatic setStepReq(input int idx);
        entry_t e;
        e = expQ[idx];
        e.sr = 1'b1;
        expQ[idx] = e;
    endtask

    task automatic applyEntry(input entry_t e);
        reset_n = e.rstn; kind = e.k; rdyB = e.rdy; wake = e.wk; stepMode = e.sm; stepReq = e.sr;
    endtask

    task automatic applyReset();
        reset_n = 1'b0; wake = 1'b0; stepMode = 1'b0; stepReq = 1'b0; rdyB = 1'b1; kind = K_MOV;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        entry_t e;
        int cyc = 0;
        applyReset();
        pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            applyEntry(e);
            @(negedge clock);
            checkCount++;
            if (obsA !== e.exp) $display("[TB] FAIL reset_a cyc %0d: got %s, want %s", cyc, fmtObs(obsA), fmtObs(e.exp));
            else passCount++;
            checkCount++;
            if (obsB !== e.exp) $display("[TB] FAIL reset_b cyc %0d: got %s, want %s", cyc, fmtObs(obsB), fmtObs(e.exp));
            else passCount++;
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back_store();
        entry_t e;
        int cyc = 0;
        applyReset();
        pushInstr(K_ST, 1'b0, 16'd0);
        pushInstr(K_ST, 1'b0, 16'd1);
        pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            applyEntry(e);
            @(negedge clock);
            checkCount++;
            if (obsA !== e.exp) $display("[TB] FAIL store cyc %0d: got %s, want %s", cyc, fmtObs(obsA), fmtObs(e.exp));
            else passCount++;
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_ready_stretch();
        entry_t e;
        int cyc = 0;
        applyReset();
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, K_MOV, i == 2, 1'b0, 1'b0, 1'b0, STATE_FETCH1, i == 2, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 7; i++)
            pushCycle(1'b1, K_MOV, !(i >= 2 && i <= 5), 1'b0, 1'b0, 1'b0, STATE_FETCH2, i == 6, 1'b0, 1'b0, 1'b0, 16'd0);
        pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b0, 1'b0, STATE_EXEC, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, K_ST, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, i == 2, 1'b0, 1'b0, 1'b0, 16'd1);
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, K_ST, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH2, i == 2, 1'b0, 1'b0, 1'b0, 16'd1);
        for (int i = 0; i < 5; i++)
            pushCycle(1'b1, K_ST, !(i == 2 || i == 3), 1'b0, 1'b0, 1'b0, STATE_EXEC, i == 4, i == 1, 1'b0, 1'b0, 16'd1);
        pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            applyEntry(e);
            @(negedge clock);
            checkCount++;
            if (obsB !== e.exp) $display("[TB] FAIL ready cyc %0d: got %s, want %s", cyc, fmtObs(obsB), fmtObs(e.exp));
            else passCount++;
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_halt_wake();
        entry_t e;
        int cyc = 0;
        applyReset();
        pushInstr(K_HLT, 1'b0, 16'd0);
        for (int i = 0; i < 6; i++)
            pushCycle(1'b1, K_MOV, 1'b1, i == 3, 1'b0, 1'b0, STATE_HALT, 1'b1, 1'b0, 1'b1, i == 5, 16'd1);
        pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            applyEntry(e);
            @(negedge clock);
            checkCount++;
            if (obsA !== e.exp) $display("[TB] FAIL halt cyc %0d: got %s, want %s", cyc, fmtObs(obsA), fmtObs(e.exp));
            else passCount++;
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_single_step();
        entry_t e;
        int cyc = 0;
        int base;
        applyReset();
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b1, i == 2, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        pushInstr(K_MOV, 1'b1, 16'd0);
        base = expQ.size() - 7;
        setStepReq(base + 1);
        for (int i = 0; i < 2; i++)
            pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b1, i == 1, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        pushInstr(K_MOV, 1'b1, 16'd1);
        base = expQ.size() - 7;
        setStepReq(base + 2);
        pushInstr(K_MOV, 1'b1, 16'd2);
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b1, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            applyEntry(e);
            @(negedge clock);
            checkCount++;
            if (obsA !== e.exp) $display("[TB] FAIL step cyc %0d: got %s, want %s", cyc, fmtObs(obsA), fmtObs(e.exp));
            else passCount++;
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid_access();
        entry_t e;
        int cyc = 0;
        applyReset();
        pushInstr(K_ST, 1'b0, 16'd0);
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, K_ST, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, i == 2, 1'b0, 1'b0, 1'b0, 16'd1);
        for (int i = 0; i < 3; i++)
            pushCycle(1'b1, K_ST, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH2, i == 2, 1'b0, 1'b0, 1'b0, 16'd1);
        pushCycle(1'b1, K_ST, 1'b1, 1'b0, 1'b0, 1'b0, STATE_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        pushCycle(1'b0, K_ST, 1'b1, 1'b0, 1'b0, 1'b0, STATE_EXEC, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
        pushCycle(1'b1, K_ST, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        pushCycle(1'b1, K_ST, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            applyEntry(e);
            @(negedge clock);
            checkCount++;
            if (obsA !== e.exp) $display("[TB] FAIL rst_mid cyc %0d: got %s, want %s", cyc, fmtObs(obsA), fmtObs(e.exp));
            else passCount++;
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_count_wrap();
        entry_t e;
        int cyc = 0;
        applyReset();
        for (int n = 0; n < 17; n++)
            pushInstr(K_MOV, 1'b0, 16'(n % 16));
        pushCycle(1'b1, K_MOV, 1'b1, 1'b0, 1'b0, 1'b0, STATE_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            applyEntry(e);
            @(negedge clock);
            checkCount++;
            if (obsB !== e.exp) $display("[TB] FAIL wrap cyc %0d: got %s, want %s", cyc, fmtObs(obsB), fmtObs(e.exp));
            else passCount++;
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0; wake = 1'b0; stepMode = 1'b0; stepReq = 1'b0; rdyB = 1'b1; kind = K_MOV;
        test_reset();
        test_back_to_back_store();
        test_ready_stretch();
        test_halt_wake();
        test_single_step();
        test_reset_mid_access();
        test_count_wrap();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
